// File: rtl/decode_pipe.sv
// Registered instruction-decode stage: R/I/U/B decode, integrated register file with
// write-back bypass, and a single valid/ready output register toward execute.
module decode_pipe #(
   parameter  int XLEN     = 32,
   parameter  int NREG     = 32,
   parameter  int SIGN_EXT = 0,
   parameter  int BYPASS   = 1,
   localparam int AW       = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     instr,
   input  logic            flush,
   input  logic            wb_we,
   input  logic [AW-1:0]   wb_addr,
   input  logic [XLEN-1:0] wb_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [6:0]      opcode,
   output logic [3:0]      func,
   output logic [AW-1:0]   rs1,
   output logic [AW-1:0]   rs2,
   output logic [AW-1:0]   rd,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   output logic [XLEN-1:0] imm,
   output logic            hata,
   output logic [7:0]      err_cnt
);

   // Handshake: a bundle moves fetch->decode when in_valid && in_ready, and
   // decode->execute when out_valid && out_ready; flush blocks acceptance.
   localparam logic [6:0] OP_R = 7'h01;
   localparam logic [6:0] OP_I = 7'h03;
   localparam logic [6:0] OP_U = 7'h07;
   localparam logic [6:0] OP_B = 7'h0F;

   logic [XLEN-1:0] r_regs [NREG];
   logic            r_out_valid;
   logic [6:0]      r_opcode;
   logic [3:0]      r_func;
   logic [AW-1:0]   r_rs1;
   logic [AW-1:0]   r_rs2;
   logic [AW-1:0]   r_rd;
   logic [XLEN-1:0] r_rs1_data;
   logic [XLEN-1:0] r_rs2_data;
   logic [XLEN-1:0] r_imm;
   logic            r_hata;
   logic [7:0]      r_err_cnt;

   logic            w_accept;
   logic            w_sx;
   logic [XLEN-1:0] w_imm_i;
   logic [XLEN-1:0] w_imm_u;
   logic [XLEN-1:0] w_imm_b;
   logic [3:0]      w_func;
   logic [AW-1:0]   w_rs1_idx;
   logic [AW-1:0]   w_rs2_idx;
   logic [AW-1:0]   w_rd_idx;
   logic [XLEN-1:0] w_imm;
   logic            w_hata;
   logic [XLEN-1:0] w_rs1_data;
   logic [XLEN-1:0] w_rs2_data;
   logic            w_hold_hit1;
   logic            w_hold_hit2;

   assign in_ready = !flush && (!r_out_valid || out_ready);
   assign w_accept = in_valid && in_ready;

   // Every immediate field has its MSB at instr[31].
   assign w_sx    = (SIGN_EXT != 0) && instr[31];
   assign w_imm_i = {{(XLEN-12){w_sx}}, instr[31:20]};
   assign w_imm_u = {{(XLEN-20){w_sx}}, instr[31:12]};
   assign w_imm_b = {{(XLEN-13){w_sx}}, instr[31:25], instr[11:7], 1'b0};

   always_comb begin
      w_func    = '0;
      w_rs1_idx = '0;
      w_rs2_idx = '0;
      w_rd_idx  = '0;
      w_imm     = '0;
      w_hata    = 1'b0;
      case (instr[6:0])
         OP_R: begin
            w_func    = {instr[30], instr[14:12]};
            w_rs1_idx = instr[15 +: AW];
            w_rs2_idx = instr[20 +: AW];
            w_rd_idx  = instr[7 +: AW];
         end
         OP_I: begin
            w_func    = {1'b0, instr[14:12]};
            w_rs1_idx = instr[15 +: AW];
            w_rd_idx  = instr[7 +: AW];
            w_imm     = w_imm_i;
         end
         OP_U: begin
            w_rd_idx  = instr[7 +: AW];
            w_imm     = w_imm_u;
         end
         OP_B: begin
            w_func    = {1'b0, instr[14:12]};
            w_rs1_idx = instr[15 +: AW];
            w_rs2_idx = instr[20 +: AW];
            w_imm     = w_imm_b;
         end
         default: w_hata = 1'b1;
      endcase
   end

   // Index 0 forces a zero operand, which also zeroes data for illegal opcodes.
   always_comb begin
      w_rs1_data = '0;
      if (w_rs1_idx != '0) begin
         if ((BYPASS != 0) && wb_we && (wb_addr == w_rs1_idx)) w_rs1_data = wb_data;
         else                                                  w_rs1_data = r_regs[w_rs1_idx];
      end
   end

   always_comb begin
      w_rs2_data = '0;
      if (w_rs2_idx != '0) begin
         if ((BYPASS != 0) && wb_we && (wb_addr == w_rs2_idx)) w_rs2_data = wb_data;
         else                                                  w_rs2_data = r_regs[w_rs2_idx];
      end
   end

   assign w_hold_hit1 = wb_we && (r_rs1 != '0) && (wb_addr == r_rs1);
   assign w_hold_hit2 = wb_we && (r_rs2 != '0) && (wb_addr == r_rs2);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      end else if (wb_we && (wb_addr != '0)) begin
         r_regs[wb_addr] <= wb_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_out_valid <= 1'b0;
         r_opcode    <= '0;
         r_func      <= '0;
         r_rs1       <= '0;
         r_rs2       <= '0;
         r_rd        <= '0;
         r_rs1_data  <= '0;
         r_rs2_data  <= '0;
         r_imm       <= '0;
         r_hata      <= 1'b0;
      end else if (flush) begin
         r_out_valid <= 1'b0;
      end else if (w_accept) begin
         r_out_valid <= 1'b1;
         r_opcode    <= instr[6:0];
         r_func      <= w_func;
         r_rs1       <= w_rs1_idx;
         r_rs2       <= w_rs2_idx;
         r_rd        <= w_rd_idx;
         r_rs1_data  <= w_rs1_data;
         r_rs2_data  <= w_rs2_data;
         r_imm       <= w_imm;
         r_hata      <= w_hata;
      end else if (r_out_valid && out_ready) begin
         r_out_valid <= 1'b0;
      end else if (r_out_valid) begin
         // Stalled: keep held operands coherent with the register file.
         if (w_hold_hit1) r_rs1_data <= wb_data;
         if (w_hold_hit2) r_rs2_data <= wb_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                                       r_err_cnt <= '0;
      else if (w_accept && w_hata && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
   end

   assign out_valid = r_out_valid;
   assign opcode    = r_opcode;
   assign func      = r_func;
   assign rs1       = r_rs1;
   assign rs2       = r_rs2;
   assign rd        = r_rd;
   assign rs1_data  = r_rs1_data;
   assign rs2_data  = r_rs2_data;
   assign imm       = r_imm;
   assign hata      = r_hata;
   assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_decode_pipe.sv
// Directed bench for decode_pipe: one sign-extending/bypassing instance and one
// zero-extending/non-bypassing instance share the same stimulus.
module tb_decode_pipe;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [31:0] instr;
   logic        flush;
   logic        wb_we;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        out_ready;

   logic        in_ready, out_valid, hata;
   logic [6:0]  opcode;
   logic [3:0]  func;
   logic [4:0]  rs1, rs2, rd;
   logic [31:0] rs1_data, rs2_data, imm;
   logic [7:0]  err_cnt;

   logic        in_ready_z, out_valid_z, hata_z;
   logic [6:0]  opcode_z;
   logic [3:0]  func_z;
   logic [4:0]  rs1_z, rs2_z, rd_z;
   logic [31:0] rs1_data_z, rs2_data_z, imm_z;
   logic [7:0]  err_cnt_z;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   decode_pipe #(.XLEN(32), .NREG(32), .SIGN_EXT(1), .BYPASS(1)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
      .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
      .out_valid(out_valid), .out_ready(out_ready), .opcode(opcode), .func(func),
      .rs1(rs1), .rs2(rs2), .rd(rd), .rs1_data(rs1_data), .rs2_data(rs2_data),
      .imm(imm), .hata(hata), .err_cnt(err_cnt)
   );

   decode_pipe #(.XLEN(32), .NREG(32), .SIGN_EXT(0), .BYPASS(0)) dut_z (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_z), .instr(instr),
      .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
      .out_valid(out_valid_z), .out_ready(out_ready), .opcode(opcode_z), .func(func_z),
      .rs1(rs1_z), .rs2(rs2_z), .rd(rd_z), .rs1_data(rs1_data_z), .rs2_data(rs2_data_z),
      .imm(imm_z), .hata(hata_z), .err_cnt(err_cnt_z)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] mk_r(input logic b30, input logic [4:0] r2, input logic [4:0] r1,
                                        input logic [2:0] f3, input logic [4:0] rdi);
      return {1'b0, b30, 5'd0, r2, r1, f3, rdi, 7'h01};
   endfunction

   task automatic wb(input logic we, input logic [4:0] a, input logic [31:0] d);
      wb_we   = we;
      wb_addr = a;
      wb_data = d;
   endtask

   initial begin
      reset = 1'b0; in_valid = 1'b0; instr = '0; flush = 1'b0;
      wb_we = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b1;
      #12;
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_rd", rd, 0);
      check_eq("rst_imm", imm, 0);
      check_eq("rst_err_cnt", err_cnt, 0);
      reset = 1'b1;
      tick();
      check_eq("rst_in_ready", in_ready, 1);

      // preload x3=10, x4=20
      wb(1, 3, 10); tick();
      wb(1, 4, 20); tick();
      wb(0, 0, 0);

      // R decode with operand read
      in_valid = 1'b1; instr = mk_r(1'b1, 4, 3, 3'd2, 5); tick();
      check_eq("r_out_valid", out_valid, 1);
      check_eq("r_rs1_data", rs1_data, 10);
      check_eq("r_rs2_data", rs2_data, 20);
      check_eq("r_rd", rd, 5);
      check_eq("r_func", func, 4'b1010);
      check_eq("r_imm", imm, 0);

      // I with imm FFF: sign- and zero-extended
      instr = {12'hFFF, 5'd3, 3'd1, 5'd6, 7'h03}; tick();
      check_eq("i_imm_sx", imm, 32'hFFFF_FFFF);
      check_eq("i_imm_zx", imm_z, 32'h0000_0FFF);
      check_eq("i_rs2", rs2, 0);
      check_eq("i_func", func, 4'h1);
      check_eq("i_rs1_data", rs1_data, 10);

      // U
      instr = {20'h80001, 5'd7, 7'h07}; tick();
      check_eq("u_imm_sx", imm, 32'hFFF8_0001);
      check_eq("u_imm_zx", imm_z, 32'h0008_0001);
      check_eq("u_rs1", rs1, 0);
      check_eq("u_rd", rd, 7);

      // B: imm13 = {7'h40, 5'h1f, 0} = 0x103E
      instr = {7'h40, 5'd4, 5'd3, 3'd0, 5'h1F, 7'h0F}; tick();
      check_eq("b_imm_sx", imm, 32'hFFFF_F03E);
      check_eq("b_imm_zx", imm_z, 32'h0000_103E);
      check_eq("b_rd", rd, 0);
      check_eq("b_rs2_data", rs2_data, 20);

      // stall with write-back to held rs1
      instr = mk_r(1'b0, 4, 3, 3'd0, 5); tick();
      out_ready = 1'b0; instr = {12'h001, 5'd4, 3'd0, 5'd9, 7'h03}; wb(1, 3, 99);
      #1 check_eq("stall_in_ready", in_ready, 0);
      tick();
      wb(0, 0, 0);
      check_eq("stall_rs1_data", rs1_data, 99);
      check_eq("stall_rs1_data_nobyp", rs1_data_z, 99);
      for (int k = 0; k < 2; k++) begin
         tick();
         check_eq("stall_valid", out_valid, 1);
         check_eq("stall_rd", rd, 5);
         check_eq("stall_opcode", opcode, 7'h01);
         check_eq("stall_rs2_data", rs2_data, 20);
      end
      out_ready = 1'b1; in_valid = 1'b0; tick();
      check_eq("drain_valid", out_valid, 0);

      // x0 write ignored, same-cycle bypass
      in_valid = 1'b1; instr = {12'h000, 5'd0, 3'd0, 5'd2, 7'h03}; wb(1, 0, 77); tick();
      check_eq("x0_rs1_data", rs1_data, 0);
      instr = mk_r(1'b0, 4, 3, 3'd0, 1); wb(1, 4, 55); tick();
      wb(0, 0, 0);
      check_eq("byp_rs2_new", rs2_data, 55);
      check_eq("nobyp_rs2_old", rs2_data_z, 20);
      check_eq("byp_rs1", rs1_data, 99);
      instr = mk_r(1'b0, 0, 4, 3'd0, 1); tick();
      check_eq("wb_committed", rs1_data_z, 55);
      check_eq("x0_read_rs2", rs2_data, 0);

      // illegal opcode, saturating counter
      check_eq("err_before", err_cnt, 0);
      instr = 32'hFFFF_FFFF;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (i == 0) begin
            check_eq("ill_hata", hata, 1);
            check_eq("ill_err1", err_cnt, 1);
            check_eq("ill_imm", imm, 0);
            check_eq("ill_rd", rd, 0);
            check_eq("ill_func", func, 0);
            check_eq("ill_rs1_data", rs1_data, 0);
            check_eq("ill_valid", out_valid, 1);
         end
         if (i == 254) check_eq("ill_err255", err_cnt, 255);
      end
      check_eq("ill_sat", err_cnt, 255);
      check_eq("ill_hata_end", hata, 1);

      // flush over a held bundle with incoming instruction
      instr = mk_r(1'b0, 4, 3, 3'd0, 5); tick();
      out_ready = 1'b0; flush = 1'b1; instr = 32'hFFFF_FFFF;
      #1 check_eq("flush_in_ready", in_ready, 0);
      tick();
      check_eq("flush_valid", out_valid, 0);
      check_eq("flush_rd_kept", rd, 5);
      check_eq("flush_hata", hata, 0);
      check_eq("flush_err", err_cnt, 255);
      flush = 1'b0; in_valid = 1'b0; tick();
      check_eq("flush_valid2", out_valid, 0);

      // async reset in the middle of a stall
      in_valid = 1'b1; instr = mk_r(1'b0, 4, 3, 3'd0, 5); tick();
      in_valid = 1'b0; tick();
      check_eq("pre_rst_valid", out_valid, 1);
      reset = 1'b0;
      #1;
      check_eq("arst_valid", out_valid, 0);
      check_eq("arst_rd", rd, 0);
      check_eq("arst_rs1_data", rs1_data, 0);
      check_eq("arst_opcode", opcode, 0);
      check_eq("arst_err", err_cnt, 0);
      reset = 1'b1; out_ready = 1'b1; tick();
      in_valid = 1'b1; tick();
      in_valid = 1'b0;
      check_eq("post_rst_rf", rs1_data, 0);
      check_eq("post_rst_valid", out_valid, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
